// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: read ports, predicate access, writeback, issue and clear control.
interface regfile_mp_if #(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned NUM_READ = 2,
    parameter int unsigned NUM_PRED = 4
);
    localparam int unsigned AW = $clog2(NUM_REGS);
    localparam int unsigned PW = $clog2(NUM_PRED);

    logic                       rd_valid;
    logic [NUM_READ*AW-1:0]     rd_addr;
    logic [NUM_READ*DATA_W-1:0] rd_data;
    logic [NUM_READ-1:0]        rd_pending;
    logic [PW-1:0]              ps_rd_addr;
    logic                       ps_rd_data;
    logic                       wr_valid;
    logic                       wr_en;
    logic [AW-1:0]              wr_addr;
    logic [DATA_W-1:0]          wr_data;
    logic                       ps_wr_en;
    logic [PW-1:0]              ps_wr_addr;
    logic                       ps_wr_data;
    logic                       issue_valid;
    logic [AW-1:0]              issue_dst_addr;
    logic                       clear_req;
    logic                       clear_busy;

    modport master (
        output rd_valid, rd_addr, ps_rd_addr,
        output wr_valid, wr_en, wr_addr, wr_data,
        output ps_wr_en, ps_wr_addr, ps_wr_data,
        output issue_valid, issue_dst_addr, clear_req,
        input  rd_data, rd_pending, ps_rd_data, clear_busy
    );

    modport slave (
        input  rd_valid, rd_addr, ps_rd_addr,
        input  wr_valid, wr_en, wr_addr, wr_data,
        input  ps_wr_en, ps_wr_addr, ps_wr_data,
        input  issue_valid, issue_dst_addr, clear_req,
        output rd_data, rd_pending, ps_rd_data, clear_busy
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with write bypass, predicate file, pending scoreboard and bulk clear.
module regfile_mp #(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned NUM_READ = 2,
    parameter int unsigned NUM_PRED = 4
) (
    input  logic         clk,
    input  logic         n_rst,
    regfile_mp_if.slave  bus
);
    localparam int unsigned AW = $clog2(NUM_REGS);
    localparam int unsigned PW = $clog2(NUM_PRED);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;

    logic [0:0]                 state;
    logic [0:0]                 next_state;
    logic [AW-1:0]              idx;
    logic                       busy;
    logic [DATA_W-1:0]          regs [NUM_REGS];
    logic [NUM_REGS-1:0]        pending;
    logic [NUM_PRED-1:0]        pred;
    logic                       idle_c;
    logic                       we_c;
    logic                       pwe_c;
    logic [AW-1:0]              ra_c;
    logic [NUM_READ*DATA_W-1:0] rd_data_c;
    logic [NUM_READ-1:0]        rd_pending_c;

    assign idle_c = (state == IDLE);
    assign we_c   = bus.wr_valid & bus.wr_en & idle_c;
    assign pwe_c  = bus.wr_valid & bus.ps_wr_en & idle_c;

    // Clear FSM next-state: one pass over the array, then back to IDLE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.clear_req) next_state = CLEAR;
            CLEAR:   if (idx == AW'(NUM_REGS - 1)) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register and registered busy flag.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state == CLEAR);
        end
    end

    // Clear index walks the array while clearing, parked at zero otherwise.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            idx <= '0;
        end else if (state == CLEAR) begin
            idx <= idx + AW'(1);
        end else begin
            idx <= '0;
        end
    end

    // Data array: writeback in IDLE, one register zeroed per cycle in CLEAR.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (state == CLEAR) begin
            regs[idx] <= '0;
        end else if (we_c) begin
            regs[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Scoreboard and predicates; a clear start wipes both, an issue beats a same-cycle writeback.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pending <= '0;
            pred    <= '0;
        end else if (idle_c) begin
            if (bus.clear_req) begin
                pending <= '0;
                pred    <= '0;
            end else begin
                if (we_c)            pending[bus.wr_addr]        <= 1'b0;
                if (bus.issue_valid) pending[bus.issue_dst_addr] <= 1'b1;
                if (pwe_c)           pred[bus.ps_wr_addr]        <= bus.ps_wr_data;
            end
        end
    end

    // Zero-latency read ports with writeback bypass; all zero when not requested.
    always_comb begin
        rd_data_c    = '0;
        rd_pending_c = '0;
        ra_c         = '0;
        for (int k = 0; k < NUM_READ; k++) begin
            ra_c = bus.rd_addr[k*AW +: AW];
            if (bus.rd_valid) begin
                if (we_c && (bus.wr_addr == ra_c)) begin
                    rd_data_c[k*DATA_W +: DATA_W] = bus.wr_data;
                end else begin
                    rd_data_c[k*DATA_W +: DATA_W] = regs[ra_c];
                    rd_pending_c[k]               = pending[ra_c];
                end
            end
        end
    end

    assign bus.rd_data    = rd_data_c;
    assign bus.rd_pending = rd_pending_c;
    assign bus.ps_rd_data = (pwe_c && (bus.ps_wr_addr == bus.ps_rd_addr)) ? bus.ps_wr_data
                                                                          : pred[bus.ps_rd_addr];
    assign bus.clear_busy = busy;

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized and directed bench for regfile_mp against a behavioural model.
module tb_regfile_mp;
    localparam int unsigned NR  = 16;
    localparam int unsigned DW  = 16;
    localparam int unsigned NRD = 2;
    localparam int unsigned NP  = 4;
    localparam int unsigned AW  = 4;
    localparam int unsigned PW  = 2;
    localparam int unsigned RAW = NRD * AW;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    regfile_mp_if #(.NUM_REGS(NR), .DATA_W(DW), .NUM_READ(NRD), .NUM_PRED(NP)) bus();

    regfile_mp #(.NUM_REGS(NR), .DATA_W(DW), .NUM_READ(NRD), .NUM_PRED(NP)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: register contents, predicates, outstanding writes, clear progress.
    logic [DW-1:0] m_regs [NR];
    logic          m_pred [NP];
    logic          m_pend [NR];
    logic          m_busy;
    int            m_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
        end
        for (int i = 0; i < NP; i++) m_pred[i] = 1'b0;
        m_busy = 1'b0;
        m_cnt  = 0;
    endtask

    task automatic idle();
        bus.rd_valid       = 1'b0;
        bus.rd_addr        = '0;
        bus.ps_rd_addr     = '0;
        bus.wr_valid       = 1'b0;
        bus.wr_en          = 1'b0;
        bus.wr_addr        = '0;
        bus.wr_data        = '0;
        bus.ps_wr_en       = 1'b0;
        bus.ps_wr_addr     = '0;
        bus.ps_wr_data     = 1'b0;
        bus.issue_valid    = 1'b0;
        bus.issue_dst_addr = '0;
        bus.clear_req      = 1'b0;
    endtask

    // Let combinational outputs settle, then compare every output with the model.
    task automatic settle();
        logic                  we;
        logic                  pwe;
        logic [AW-1:0]         a;
        logic [NRD*DW-1:0]     ed;
        logic [NRD-1:0]        ep;
        logic                  eps;
        #2;
        we  = bus.wr_valid & bus.wr_en & ~m_busy;
        pwe = bus.wr_valid & bus.ps_wr_en & ~m_busy;
        ed  = '0;
        ep  = '0;
        for (int k = 0; k < NRD; k++) begin
            a = bus.rd_addr[k*AW +: AW];
            if (bus.rd_valid) begin
                if (we && bus.wr_addr == a) ed[k*DW +: DW] = bus.wr_data;
                else                        ed[k*DW +: DW] = m_regs[a];
                ep[k] = m_pend[a] & ~(we && bus.wr_addr == a);
            end
        end
        eps = (pwe && bus.ps_wr_addr == bus.ps_rd_addr) ? bus.ps_wr_data : m_pred[bus.ps_rd_addr];
        check("rd_data",    64'(bus.rd_data),    64'(ed));
        check("rd_pending", 64'(bus.rd_pending), 64'(ep));
        check("ps_rd_data", 64'(bus.ps_rd_data), 64'(eps));
        check("clear_busy", 64'(bus.clear_busy), 64'(m_busy));
    endtask

    // Advance one clock and apply the same cycle's inputs to the model.
    task automatic tick();
        logic we;
        logic pwe;
        @(posedge clk);
        if (n_rst) begin
            if (m_busy) begin
                m_regs[m_cnt] = '0;
                m_cnt++;
                if (m_cnt == NR) m_busy = 1'b0;
            end else begin
                we  = bus.wr_valid & bus.wr_en;
                pwe = bus.wr_valid & bus.ps_wr_en;
                if (we) m_regs[bus.wr_addr] = bus.wr_data;
                if (bus.clear_req) begin
                    for (int i = 0; i < NR; i++) m_pend[i] = 1'b0;
                    for (int i = 0; i < NP; i++) m_pred[i] = 1'b0;
                    m_busy = 1'b1;
                    m_cnt  = 0;
                end else begin
                    if (pwe)             m_pred[bus.ps_wr_addr]     = bus.ps_wr_data;
                    if (we)              m_pend[bus.wr_addr]        = 1'b0;
                    if (bus.issue_valid) m_pend[bus.issue_dst_addr] = 1'b1;
                end
            end
        end
        @(negedge clk);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset();
        #1;
        n_rst = 1'b0;
        #1;
        model_reset();
        check("rst_busy", 64'(bus.clear_busy), 64'(0));
        n_rst = 1'b1;
    endtask

    task automatic write_reg(input int a, input logic [DW-1:0] d);
        idle();
        bus.wr_valid = 1'b1;
        bus.wr_en    = 1'b1;
        bus.wr_addr  = AW'(a);
        bus.wr_data  = d;
    endtask

    int n_busy;

    initial begin
        idle();
        model_reset();
        bus.rd_valid = 1'b1;
        bus.rd_addr  = {AW'(7), AW'(2)};
        #3;
        check("rst_rd_data", 64'(bus.rd_data), 64'(0));
        check("rst_pending", 64'(bus.rd_pending), 64'(0));
        check("rst_busy0",   64'(bus.clear_busy), 64'(0));
        @(negedge clk);
        n_rst = 1'b1;

        // Fresh array reads zero on every address.
        for (int i = 0; i < NR; i++) begin
            idle();
            bus.rd_valid   = 1'b1;
            bus.rd_addr    = {AW'(NR - 1 - i), AW'(i)};
            bus.ps_rd_addr = PW'(i);
            settle();
            check("rst_all_rd", 64'(bus.rd_data), 64'(0));
            tick();
        end

        // Write bypass, then array value on both ports.
        write_reg(5, 16'hBEEF);
        bus.rd_valid = 1'b1;
        bus.rd_addr  = {AW'(0), AW'(5)};
        settle();
        check("bypass_p0", 64'(bus.rd_data[DW-1:0]), 64'(16'hBEEF));
        tick();
        idle();
        bus.rd_valid = 1'b1;
        bus.rd_addr  = {AW'(5), AW'(5)};
        settle();
        check("array_p0", 64'(bus.rd_data[DW-1:0]),  64'(16'hBEEF));
        check("array_p1", 64'(bus.rd_data[2*DW-1:DW]), 64'(16'hBEEF));
        tick();
        idle();
        settle();
        check("rd_valid0", 64'(bus.rd_data), 64'(0));
        tick();

        // Scoreboard set, resolved by bypass, and set-wins on collision.
        idle();
        bus.issue_valid    = 1'b1;
        bus.issue_dst_addr = AW'(3);
        settle();
        tick();
        idle();
        bus.rd_valid = 1'b1;
        bus.rd_addr  = {AW'(3), AW'(3)};
        settle();
        check("pend_set", 64'(bus.rd_pending), 64'(2'b11));
        tick();
        write_reg(3, 16'h0033);
        bus.rd_valid = 1'b1;
        bus.rd_addr  = {AW'(3), AW'(3)};
        settle();
        check("pend_bypass", 64'(bus.rd_pending), 64'(2'b00));
        tick();
        idle();
        bus.rd_valid = 1'b1;
        bus.rd_addr  = {AW'(3), AW'(3)};
        settle();
        check("pend_cleared", 64'(bus.rd_pending), 64'(2'b00));
        tick();
        write_reg(3, 16'h0044);
        bus.issue_valid    = 1'b1;
        bus.issue_dst_addr = AW'(3);
        settle();
        tick();
        idle();
        bus.rd_valid = 1'b1;
        bus.rd_addr  = {AW'(3), AW'(3)};
        settle();
        check("pend_set_wins", 64'(bus.rd_pending), 64'(2'b11));
        tick();

        // Predicate bypass, readback, and reset.
        idle();
        bus.wr_valid   = 1'b1;
        bus.ps_wr_en   = 1'b1;
        bus.ps_wr_addr = PW'(2);
        bus.ps_wr_data = 1'b1;
        bus.ps_rd_addr = PW'(2);
        settle();
        check("pred_bypass", 64'(bus.ps_rd_data), 64'(1));
        tick();
        idle();
        bus.ps_rd_addr = PW'(1);
        settle();
        check("pred1", 64'(bus.ps_rd_data), 64'(0));
        tick();
        idle();
        bus.ps_rd_addr = PW'(2);
        settle();
        check("pred2", 64'(bus.ps_rd_data), 64'(1));
        async_reset();
        settle();
        check("pred2_rst", 64'(bus.ps_rd_data), 64'(0));
        tick();

        // Load the array, then bulk clear with a dropped write in the middle.
        for (int i = 0; i < NR; i++) begin
            write_reg(i, DW'(16'h1000 + i));
            bus.issue_valid    = 1'b1;
            bus.issue_dst_addr = AW'(NR - 1 - i);
            settle();
            tick();
        end
        idle();
        bus.rd_addr = {AW'(9), AW'(4)};
        settle();
        check("rd_valid0_full", 64'(bus.rd_data), 64'(0));
        tick();
        idle();
        bus.clear_req = 1'b1;
        settle();
        tick();
        n_busy = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            idle();
            bus.rd_valid = 1'b1;
            bus.rd_addr  = {AW'(cyc), AW'(0)};
            if (cyc == 2) begin
                write_reg(0, 16'h7777);
                bus.rd_valid = 1'b1;
                bus.clear_req = 1'b1;
            end
            settle();
            if (!bus.clear_busy) break;
            n_busy++;
            tick();
        end
        check("clear_len", 64'(n_busy), 64'(NR));
        for (int i = 0; i < NR; i++) begin
            idle();
            bus.rd_valid = 1'b1;
            bus.rd_addr  = {AW'(i), AW'(i)};
            settle();
            check("clr_reg",  64'(bus.rd_data),    64'(0));
            check("clr_pend", 64'(bus.rd_pending), 64'(0));
            tick();
        end

        // Reset in the middle of a clear, then restart cleanly.
        write_reg(9, 16'hAAAA);
        settle();
        tick();
        idle();
        bus.clear_req = 1'b1;
        settle();
        tick();
        for (int c = 0; c < 4; c++) begin
            idle();
            settle();
            tick();
        end
        idle();
        async_reset();
        check("midclr_busy", 64'(bus.clear_busy), 64'(0));
        settle();
        tick();
        write_reg(9, 16'h1234);
        settle();
        tick();
        idle();
        bus.rd_valid = 1'b1;
        bus.rd_addr  = {AW'(9), AW'(9)};
        settle();
        check("restart_rd", 64'(bus.rd_data), 64'({16'h1234, 16'h1234}));
        tick();

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            bus.rd_valid       = ($urandom % 4) != 0;
            bus.rd_addr        = RAW'($urandom);
            bus.ps_rd_addr     = PW'($urandom);
            bus.wr_valid       = ($urandom % 2) != 0;
            bus.wr_en          = ($urandom % 3) != 0;
            bus.wr_addr        = AW'($urandom);
            bus.wr_data        = DW'($urandom);
            bus.ps_wr_en       = ($urandom % 2) != 0;
            bus.ps_wr_addr     = PW'($urandom);
            bus.ps_wr_data     = 1'($urandom);
            bus.issue_valid    = ($urandom % 3) == 0;
            bus.issue_dst_addr = AW'($urandom);
            bus.clear_req      = ($urandom % 60) == 0;
            if (($urandom % 400) == 0) async_reset();
            settle();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
